// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM states, the
// M-extension funct3/funct7 codes and operand signedness helpers.
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [6:0] FUNCT7_M_DEFAULT = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   function automatic logic signedA(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic signedB(input logic [2:0] f3);
      return (f3 == F3_MUL) || (f3 == F3_MULH) ||
             (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result handshake bundle of the multiply/divide unit; signal suffixes
// are named from the unit's point of view.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            valid_i;
   logic            ready_o;
   logic [2:0]      funct3_i;
   logic [6:0]      funct7_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            flush_i;
   logic            result_valid_o;
   logic            result_ready_i;
   logic [XLEN-1:0] result_o;
   logic            illegal_o;

   modport master (
      output valid_i, funct3_i, funct7_i, rs1_i, rs2_i, flush_i, result_ready_i,
      input  ready_o, result_valid_o, result_o, illegal_o
   );

   modport slave (
      input  valid_i, funct3_i, funct7_i, rs1_i, rs2_i, flush_i, result_ready_i,
      output ready_o, result_valid_o, result_o, illegal_o
   );
endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on operand magnitudes: shift-add multiply step or
// restoring divide step, selected by isDiv_i.
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic            isDiv_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   logic [XLEN:0]   addend;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   remShift;
   logic [XLEN-1:0] diff;

   // Divide: hi holds the partial remainder, lo shifts the dividend out and the
   // quotient in. The remainder stays below b, so diff fits in XLEN bits.
   // Multiply: hi accumulates, the product shifts down through lo.
   always_comb begin
      hi_o     = hi_i;
      lo_o     = lo_i;
      addend   = '0;
      sum      = '0;
      remShift = '0;
      diff     = '0;
      if (isDiv_i) begin
         remShift = {hi_i, lo_i[XLEN-1]};
         diff     = remShift[XLEN-1:0] - b_i;
         if (remShift >= {1'b0, b_i}) begin
            hi_o = diff;
            lo_o = {lo_i[XLEN-2:0], 1'b1};
         end else begin
            hi_o = remShift[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b0};
         end
      end else begin
         addend = lo_i[0] ? {1'b0, b_i} : '0;
         sum    = {1'b0, hi_i} + addend;
         hi_o   = sum[XLEN:1];
         lo_o   = {sum[0], lo_i[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: XLEN-cycle multiply/divide on magnitudes
// with sign correction, single-cycle special cases and a held result handshake.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int         XLEN     = 32,
   parameter logic [6:0] FUNCT7_M = FUNCT7_M_DEFAULT
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   muldiv_unit_if.slave bus
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = '1;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      op_q, op_d;
   logic            negRes_q, negRes_d;
   logic            illegal_q, illegal_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] res_q, res_d;

   logic [XLEN-1:0] stepHi, stepLo;
   logic            aNeg, bNeg;
   logic [XLEN-1:0] absA, absB;
   logic            isDivOp, isSignedDivOp;
   logic [2*XLEN-1:0] prodMag, prodFinal;
   logic [XLEN-1:0] quoFinal, remFinal, finalRes;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .isDiv_i (op_q[2]),
      .hi_i    (hi_q),
      .lo_i    (lo_q),
      .b_i     (b_q),
      .hi_o    (stepHi),
      .lo_o    (stepLo)
   );

   assign aNeg          = signedA(bus.funct3_i) & bus.rs1_i[XLEN-1];
   assign bNeg          = signedB(bus.funct3_i) & bus.rs2_i[XLEN-1];
   assign absA          = aNeg ? -bus.rs1_i : bus.rs1_i;
   assign absB          = bNeg ? -bus.rs2_i : bus.rs2_i;
   assign isDivOp       = bus.funct3_i[2];
   assign isSignedDivOp = (bus.funct3_i == F3_DIV) || (bus.funct3_i == F3_REM);

   // Sign correction applied to the output of the final iteration, so the
   // corrected result can be captured on the edge that enters DONE.
   assign prodMag   = {stepHi, stepLo};
   assign prodFinal = negRes_q ? -prodMag : prodMag;
   assign quoFinal  = negRes_q ? -stepLo : stepLo;
   assign remFinal  = negRes_q ? -stepHi : stepHi;

   always_comb begin
      finalRes = '0;
      case (op_q)
         F3_MUL:                       finalRes = prodFinal[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: finalRes = prodFinal[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              finalRes = quoFinal;
         default:                      finalRes = remFinal;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         negRes_q  <= 1'b0;
         illegal_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         b_q       <= '0;
         res_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         negRes_q  <= negRes_d;
         illegal_q <= illegal_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         b_q       <= b_d;
         res_q     <= res_d;
      end
   end

   // Multiply and divide load identically: hi cleared, |a| in lo, |b| in b.
   // Flush beats both accept and the result handshake.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      negRes_d  = negRes_q;
      illegal_d = illegal_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      b_d       = b_q;
      res_d     = res_q;
      if (bus.flush_i) begin
         state_d   = ST_IDLE;
         res_d     = '0;
         illegal_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.valid_i) begin
                  op_d      = bus.funct3_i;
                  illegal_d = 1'b0;
                  res_d     = '0;
                  if (bus.funct7_i != FUNCT7_M) begin
                     illegal_d = 1'b1;
                     state_d   = ST_DONE;
                  end else if (isDivOp && (bus.rs2_i == '0)) begin
                     res_d   = bus.funct3_i[1] ? bus.rs1_i : ALL_ONES;
                     state_d = ST_DONE;
                  end else if (isSignedDivOp && (bus.rs1_i == MOST_NEG) &&
                               (bus.rs2_i == ALL_ONES)) begin
                     res_d   = bus.funct3_i[1] ? '0 : bus.rs1_i;
                     state_d = ST_DONE;
                  end else begin
                     state_d  = ST_BUSY;
                     cnt_d    = CW'(XLEN - 1);
                     negRes_d = (bus.funct3_i == F3_REM) ? aNeg : (aNeg ^ bNeg);
                     hi_d     = '0;
                     lo_d     = absA;
                     b_d      = absB;
                  end
               end
            end
            ST_BUSY: begin
               hi_d = stepHi;
               lo_d = stepLo;
               if (cnt_q == '0) begin
                  state_d = ST_DONE;
                  res_d   = finalRes;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            ST_DONE: begin
               if (bus.result_ready_i) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign bus.ready_o        = (state_q == ST_IDLE);
   assign bus.result_valid_o = (state_q == ST_DONE);
   assign bus.result_o       = (state_q == ST_DONE) ? res_q : '0;
   assign bus.illegal_o      = (state_q == ST_DONE) & illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at XLEN=32: a vector table of
// hand-computed results plus flush, reset and result-hold sequences.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   localparam int XLEN = 32;

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ill;
      int          edges;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   assertCount = 0;
   int   failCount   = 0;
   vec_t vecs[$];

   muldiv_unit_if #(.XLEN(XLEN)) bus ();

   muldiv_unit #(.XLEN(XLEN), .FUNCT7_M(7'b0000001)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t mk(input string n, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] r, input logic ill, input int e);
      vec_t v;
      v.name = n; v.f3 = f3; v.f7 = f7; v.a = a; v.b = b;
      v.res = r; v.ill = ill; v.edges = e;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called just after a negedge; returns 1ns after the accept edge with the
   // operand inputs scrambled so that only latched values can be used.
   task automatic applyStimulus(input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b);
      bus.valid_i        = 1'b1;
      bus.funct3_i       = f3;
      bus.funct7_i       = f7;
      bus.rs1_i          = a;
      bus.rs2_i          = b;
      bus.result_ready_i = 1'b0;
      @(posedge clk);
      #1;
      bus.valid_i  = 1'b0;
      bus.rs1_i    = ~a;
      bus.rs2_i    = b ^ 32'h5A5A_0F0F;
      bus.funct3_i = ~f3;
   endtask

   // Counts clock edges after the accept edge until result_valid_o is seen.
   task automatic waitResult(output int edges);
      edges = 0;
      while (bus.result_valid_o !== 1'b1 && edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic takeResult();
      @(negedge clk);
      bus.result_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.result_ready_i = 1'b0;
   endtask

   initial begin
      int   edges;
      int   sawValid;
      logic [31:0] heldRes;

      bus.valid_i = 1'b0; bus.funct3_i = '0; bus.funct7_i = '0;
      bus.rs1_i = '0; bus.rs2_i = '0; bus.flush_i = 1'b0; bus.result_ready_i = 1'b0;

      vecs.push_back(mk("MUL 7*-3",         F3_MUL,    7'h01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 32));
      vecs.push_back(mk("MUL -1*2",         F3_MUL,    7'h01, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0, 32));
      vecs.push_back(mk("MULH min*min",     F3_MULH,   7'h01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 32));
      vecs.push_back(mk("MULH max*max",     F3_MULH,   7'h01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 1'b0, 32));
      vecs.push_back(mk("MULH -1*7",        F3_MULH,   7'h01, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0, 32));
      vecs.push_back(mk("MULHU ones*ones",  F3_MULHU,  7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 32));
      vecs.push_back(mk("MULHSU -1*ones",   F3_MULHSU, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32));
      vecs.push_back(mk("DIVU 100/7",       F3_DIVU,   7'h01, 32'd100,       32'd7,         32'd14,        1'b0, 32));
      vecs.push_back(mk("REMU 100/7",       F3_REMU,   7'h01, 32'd100,       32'd7,         32'd2,         1'b0, 32));
      vecs.push_back(mk("DIV -100/7",       F3_DIV,    7'h01, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0, 32));
      vecs.push_back(mk("REM -100/7",       F3_REM,    7'h01, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 1'b0, 32));
      vecs.push_back(mk("DIV 100/-7",       F3_DIV,    7'h01, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 32));
      vecs.push_back(mk("REM 100/-7",       F3_REM,    7'h01, 32'd100,       32'hFFFF_FFF9, 32'd2,         1'b0, 32));
      vecs.push_back(mk("DIVU min/ones",    F3_DIVU,   7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 32));
      vecs.push_back(mk("REMU min/ones",    F3_REMU,   7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32));
      vecs.push_back(mk("DIV 100/0",        F3_DIV,    7'h01, 32'd100,       32'd0,         32'hFFFF_FFFF, 1'b0, 0));
      vecs.push_back(mk("REM 100/0",        F3_REM,    7'h01, 32'd100,       32'd0,         32'd100,       1'b0, 0));
      vecs.push_back(mk("DIVU 5/0",         F3_DIVU,   7'h01, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 0));
      vecs.push_back(mk("REMU 5/0",         F3_REMU,   7'h01, 32'd5,         32'd0,         32'd5,         1'b0, 0));
      vecs.push_back(mk("DIV ovf",          F3_DIV,    7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0));
      vecs.push_back(mk("REM ovf",          F3_REM,    7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 0));
      vecs.push_back(mk("illegal f7=0x20",  F3_MUL,    7'h20, 32'd3,         32'd4,         32'd0,         1'b1, 0));

      // Outputs while reset is held
      #1;
      checkOutput("reset ready_o",        64'(bus.ready_o),        64'd1);
      checkOutput("reset result_valid_o", 64'(bus.result_valid_o), 64'd0);
      checkOutput("reset result_o",       64'(bus.result_o),       64'd0);
      checkOutput("reset illegal_o",      64'(bus.illegal_o),      64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] running %0d table vectors", vecs.size());
      foreach (vecs[i]) begin
         @(negedge clk);
         checkOutput({vecs[i].name, " ready before"}, 64'(bus.ready_o), 64'd1);
         applyStimulus(vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
         waitResult(edges);
         checkOutput({vecs[i].name, " latency"}, 64'(edges),            64'(vecs[i].edges));
         checkOutput({vecs[i].name, " result"},  64'(bus.result_o),     64'(vecs[i].res));
         checkOutput({vecs[i].name, " illegal"}, 64'(bus.illegal_o),    64'(vecs[i].ill));
         checkOutput({vecs[i].name, " ready in DONE"}, 64'(bus.ready_o), 64'd0);
         takeResult();
         checkOutput({vecs[i].name, " valid after take"}, 64'(bus.result_valid_o), 64'd0);
         checkOutput({vecs[i].name, " result after take"}, 64'(bus.result_o),      64'd0);
      end

      // Illegal op held in DONE without result_ready_i
      @(negedge clk);
      applyStimulus(F3_DIV, 7'h00, 32'd77, 32'd3);
      waitResult(edges);
      checkOutput("illegal latency", 64'(edges), 64'd0);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         checkOutput("illegal hold valid",   64'(bus.result_valid_o), 64'd1);
         checkOutput("illegal hold flag",    64'(bus.illegal_o),      64'd1);
         checkOutput("illegal hold result",  64'(bus.result_o),       64'd0);
         checkOutput("illegal hold ready_o", 64'(bus.ready_o),        64'd0);
      end

      // Asynchronous reset while in DONE clears outputs without a clock edge
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst in DONE valid",   64'(bus.result_valid_o), 64'd0);
      checkOutput("rst in DONE illegal", 64'(bus.illegal_o),      64'd0);
      checkOutput("rst in DONE ready_o", 64'(bus.ready_o),        64'd1);

      // Accept on the very first edge after release
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(F3_DIVU, 7'h01, 32'd100, 32'd7);
      waitResult(edges);
      checkOutput("post-reset latency", 64'(edges),         64'd32);
      checkOutput("post-reset result",  64'(bus.result_o),  64'd14);
      takeResult();

      // Result held stable in DONE over several cycles
      @(negedge clk);
      applyStimulus(F3_DIV, 7'h01, 32'd100, 32'd0);
      waitResult(edges);
      heldRes = bus.result_o;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("div0 held result", 64'(bus.result_o), 64'(heldRes));
      checkOutput("div0 held value",  64'(heldRes),      64'hFFFF_FFFF);
      // Flush beats the result handshake
      @(negedge clk);
      bus.flush_i = 1'b1;
      bus.result_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      bus.result_ready_i = 1'b0;
      checkOutput("flush DONE ready_o", 64'(bus.ready_o),        64'd1);
      checkOutput("flush DONE valid",   64'(bus.result_valid_o), 64'd0);

      // Flush in BUSY cycle 10
      @(negedge clk);
      applyStimulus(F3_MUL, 7'h01, 32'd7, 32'hFFFF_FFFD);
      repeat (9) @(posedge clk);
      @(negedge clk);
      checkOutput("busy ready_o", 64'(bus.ready_o), 64'd0);
      bus.flush_i = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      checkOutput("flush BUSY ready_o", 64'(bus.ready_o),        64'd1);
      checkOutput("flush BUSY valid",   64'(bus.result_valid_o), 64'd0);
      sawValid = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (bus.result_valid_o === 1'b1) sawValid++;
      end
      checkOutput("flush no late result", 64'(sawValid), 64'd0);

      // Reset pulse in the middle of a multiply
      @(negedge clk);
      applyStimulus(F3_MULHU, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst in BUSY ready_o", 64'(bus.ready_o),        64'd1);
      checkOutput("rst in BUSY valid",   64'(bus.result_valid_o), 64'd0);
      checkOutput("rst in BUSY result",  64'(bus.result_o),       64'd0);
      checkOutput("rst in BUSY illegal", 64'(bus.illegal_o),      64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(F3_REM, 7'h01, 32'hFFFF_FF9C, 32'd7);
      waitResult(edges);
      checkOutput("after BUSY rst latency", 64'(edges),        64'd32);
      checkOutput("after BUSY rst result",  64'(bus.result_o), 64'hFFFF_FFFE);
      takeResult();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
